vga_sync_decoder: RTL and testbench

Receive-side counterpart of the CPU top's VGA output (hs, vs, vgar/vgag/vgab). Samples the sync and colour lines on a pixel clock enable, recovers pixel coordinates, checks line/frame timing against parameters, and reports lock status, pixel stream and error counts. Sits beside `top` in the pipeline_cpu design as an on-chip display-path checker; it drives no CPU state.

---
 rtl/vga_sync_decoder.sv | 166 ++++++++++++++++
 tb/tb_vga_sync_decoder.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_decoder.sv
// Receive-side VGA checker: recovers pixel coordinates from sampled hs/vs/colour, verifies line/frame timing, tracks lock.
// Optional per-frame colour checksum on frame_sum is enabled by defining VGA_FRAME_SUM_EN.
module vga_sync_decoder #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter int SYNC_POL  = 0
) (
    input  logic        clk100m,
    input  logic        rst,
    input  logic        pix_ce,
    input  logic        hs,
    input  logic        vs,
    input  logic [3:0]  vgar,
    input  logic [3:0]  vgag,
    input  logic [3:0]  vgab,
    output logic        locked,
    output logic        px_valid,
    output logic [9:0]  px_x,
    output logic [9:0]  px_y,
    output logic [11:0] px_rgb,
    output logic        frame_start,
    output logic        timing_err,
    output logic [7:0]  err_cnt,
    output logic [15:0] frame_sum,
    output logic [1:0]  fsm_state
);
    localparam logic [9:0] H_LAST  = 10'(H_SYNC + H_BACK + H_VISIBLE + H_FRONT - 1);
    localparam logic [9:0] V_LAST  = 10'(V_SYNC + V_BACK + V_VISIBLE + V_FRONT - 1);
    localparam logic [9:0] H_START = 10'(H_SYNC + H_BACK);
    localparam logic [9:0] H_END   = 10'(H_SYNC + H_BACK + H_VISIBLE);
    localparam logic [9:0] V_START = 10'(V_SYNC + V_BACK);
    localparam logic [9:0] V_END   = 10'(V_SYNC + V_BACK + V_VISIBLE);
    localparam logic [9:0] V_SLEN  = 10'(V_SYNC);
    localparam logic [9:0] CNT_MAX = 10'h3FF;
    localparam logic       ACT     = 1'(SYNC_POL);

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    state_t     state;
    logic       hs_seen, vs_seen;
    logic [9:0] h_cnt, v_cnt, vs_run;
    logic       hs_act, vs_act, h_edge, v_start, v_end;
    logic [9:0] h_pos, v_pos;
    logic       line_err, frame_err, width_err, err, in_view;

    assign fsm_state = state;

    // h_pos/v_pos are the coordinates of the current sample after counter update.
    always_comb begin
        hs_act    = (hs == ACT);
        vs_act    = (vs == ACT);
        h_edge    = pix_ce && hs_act && !hs_seen;
        v_start   = h_edge && vs_act && !vs_seen;
        v_end     = h_edge && !vs_act && vs_seen;
        h_pos     = h_edge ? 10'd0 : ((h_cnt == CNT_MAX) ? CNT_MAX : h_cnt + 10'd1);
        v_pos     = v_cnt;
        if (v_start)
            v_pos = 10'd0;
        else if (h_edge && (v_cnt != CNT_MAX))
            v_pos = v_cnt + 10'd1;
        line_err  = h_edge && (h_cnt != H_LAST);
        frame_err = v_start && (v_cnt != V_LAST);
        width_err = v_end && (vs_run != V_SLEN);
        err       = (state != ST_SEARCH) && (line_err || frame_err || width_err);
        in_view   = (h_pos >= H_START) && (h_pos < H_END) && (v_pos >= V_START) && (v_pos < V_END);
    end

    always_ff @(posedge clk100m) begin
        if (rst) begin
            state       <= ST_SEARCH;
            hs_seen     <= 1'b0;
            vs_seen     <= 1'b0;
            h_cnt       <= '0;
            v_cnt       <= '0;
            vs_run      <= '0;
            locked      <= 1'b0;
            px_valid    <= 1'b0;
            px_x        <= '0;
            px_y        <= '0;
            px_rgb      <= '0;
            frame_start <= 1'b0;
            timing_err  <= 1'b0;
            err_cnt     <= '0;
        end else begin
            px_valid    <= 1'b0;
            frame_start <= 1'b0;
            timing_err  <= 1'b0;
            if (pix_ce) begin
                hs_seen <= hs_act;
                h_cnt   <= h_pos;
                if (h_edge) begin
                    vs_seen <= vs_act;
                    v_cnt   <= v_pos;
                    if (v_start)
                        vs_run <= 10'd1;
                    else if (vs_act && (vs_run != CNT_MAX))
                        vs_run <= vs_run + 10'd1;
                end
                if ((state == ST_LOCKED) && in_view) begin
                    px_valid <= 1'b1;
                    px_x     <= h_pos - H_START;
                    px_y     <= v_pos - V_START;
                    px_rgb   <= {vgar, vgag, vgab};
                end
                // An error on a vsync-start sample takes priority over lock progress.
                if (err) begin
                    timing_err <= 1'b1;
                    if (err_cnt != 8'hFF)
                        err_cnt <= err_cnt + 8'd1;
                    state  <= ST_SEARCH;
                    locked <= 1'b0;
                end else if (v_start) begin
                    case (state)
                        ST_SEARCH: state <= ST_VERIFY;
                        ST_VERIFY: begin
                            state  <= ST_LOCKED;
                            locked <= 1'b1;
                        end
                        ST_LOCKED: frame_start <= 1'b1;
                        default: begin
                            state  <= ST_SEARCH;
                            locked <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

`ifdef VGA_FRAME_SUM_EN
    logic [15:0] acc, acc_next;
    logic        take_sum;

    always_comb begin
        acc_next = acc + (px_valid ? {4'h0, px_rgb} : 16'h0000);
        take_sum = v_start && !err && (state != ST_SEARCH);
    end

    always_ff @(posedge clk100m) begin
        if (rst) begin
            acc       <= '0;
            frame_sum <= '0;
        end else if ((pix_ce && err) || (state == ST_SEARCH)) begin
            acc <= '0;
        end else if (take_sum) begin
            frame_sum <= acc_next;
            acc       <= '0;
        end else begin
            acc <= acc_next;
        end
    end
`else
    assign frame_sum = 16'h0000;
`endif

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Randomised line/frame stream against a line-level reference model; scoreboard queues drained by a monitor.
module tb_vga_sync_decoder;
  localparam int HV = 8, HF = 2, HS = 3, HB = 2;
  localparam int VV = 5, VF = 1, VS = 2, VB = 2;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int HST = HS + HB;
  localparam int VST = VS + VB;
  localparam logic SP = 1'b0;

  logic        clk, rst, pix_ce, hs, vs;
  logic [3:0]  vgar, vgag, vgab;
  logic        locked, px_valid, frame_start, timing_err;
  logic [9:0]  px_x, px_y;
  logic [11:0] px_rgb;
  logic [7:0]  err_cnt;
  logic [15:0] frame_sum;
  logic [1:0]  fsm_state;

  vga_sync_decoder #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB), .SYNC_POL(0)
  ) dut (
    .clk100m(clk), .rst(rst), .pix_ce(pix_ce), .hs(hs), .vs(vs),
    .vgar(vgar), .vgag(vgag), .vgab(vgab),
    .locked(locked), .px_valid(px_valid), .px_x(px_x), .px_y(px_y), .px_rgb(px_rgb),
    .frame_start(frame_start), .timing_err(timing_err), .err_cnt(err_cnt),
    .frame_sum(frame_sum), .fsm_state(fsm_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard
  logic [31:0] exp_px_q[$];
  logic [7:0]  exp_err_q[$];
  logic [15:0] exp_fs_q[$];
  logic        exp_lock_q[$];
  int n_cmp = 0, n_bad = 0, px_seen = 0, px_pushed = 0;
  bit mon_on = 1'b0;
  logic prev_locked = 1'b0;

  // reference model state (line granularity)
  int st, v_line, vs_run_m, prev_len, err_cnt_m;
  bit vs_prev_m;
  logic [15:0] sum_m;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  task automatic unexpected(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: strobe seen with nothing expected", name);
  endtask

  task automatic model_reset();
    st = 0; v_line = 0; vs_run_m = 0; prev_len = 0; err_cnt_m = 0;
    vs_prev_m = 1'b0; sum_m = '0;
  endtask

  // driver tasks
  task automatic sample(input bit hs_on, input bit vs_on, input logic [11:0] c);
    @(negedge clk);
    pix_ce = 1'b0;
    repeat ($urandom_range(1, 3)) @(negedge clk);
    hs = hs_on ? SP : ~SP;
    vs = vs_on ? SP : ~SP;
    {vgar, vgag, vgab} = c;
    pix_ce = 1'b1;
  endtask

  task automatic send_line(input int len, input bit v);
    int st0;
    bit vstart, verr, lk;
    logic [11:0] c;
    st0 = st;
    vstart = v && !vs_prev_m;
    verr = (st != 0) && ((prev_len != HT) || (vstart && v_line != VT - 1) ||
                         (!v && vs_prev_m && vs_run_m != VS));
    if (vstart) v_line = 0; else if (v_line < 1023) v_line++;
    if (vstart) vs_run_m = 1; else if (v && vs_run_m < 1023) vs_run_m++;
    vs_prev_m = v;
    if (verr) begin
      if (err_cnt_m < 255) err_cnt_m++;
      exp_err_q.push_back(8'(err_cnt_m));
      if (st == 2) exp_lock_q.push_back(1'b0);
      st = 0;
      sum_m = '0;
    end else if (vstart) begin
      if (st == 0) st = 1;
      else if (st == 1) begin
        st = 2;
        exp_lock_q.push_back(1'b1);
        sum_m = '0;
      end else begin
`ifdef VGA_FRAME_SUM_EN
        exp_fs_q.push_back(sum_m);
`else
        exp_fs_q.push_back(16'h0000);
`endif
        sum_m = '0;
      end
    end
    for (int p = 0; p < len; p++) begin
      c = 12'($urandom);
      lk = (p == 0) ? (st0 == 2) : (st == 2);
      if (lk && p >= HST && p < HST + HV && v_line >= VST && v_line < VST + VV) begin
        exp_px_q.push_back({10'(p - HST), 10'(v_line - VST), c});
        sum_m = sum_m + 16'(c);
        px_pushed++;
      end
      sample(p < HS, v, c);
    end
    prev_len = len;
  endtask

  task automatic send_part(input int first, input int last, input int short_line, input int vsw);
    for (int l = first; l <= last; l++)
      send_line((l == short_line) ? HT - 1 : HT, l < vsw);
  endtask

  task automatic send_frame(input int short_line, input int vsw);
    send_part(0, VT - 1, short_line, vsw);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    pix_ce = 1'b0;
    rst = 1'b1;
    if (st == 2) exp_lock_q.push_back(1'b0);
    @(negedge clk);
    rst = 1'b0;
    check("rst_locked", locked, 0);
    check("rst_px_valid", px_valid, 0);
    check("rst_px_x", px_x, 0);
    check("rst_px_y", px_y, 0);
    check("rst_px_rgb", px_rgb, 0);
    check("rst_frame_start", frame_start, 0);
    check("rst_timing_err", timing_err, 0);
    check("rst_err_cnt", err_cnt, 0);
    check("rst_frame_sum", frame_sum, 0);
    check("rst_state", fsm_state, 0);
    model_reset();
  endtask

  // monitor
  always @(negedge clk) begin
    if (mon_on) begin
      if (px_valid) begin
        px_seen++;
        if (exp_px_q.size() == 0) unexpected("px_valid");
        else check("pixel", {px_x, px_y, px_rgb}, exp_px_q.pop_front());
      end
      if (timing_err) begin
        if (exp_err_q.size() == 0) unexpected("timing_err");
        else check("err_cnt", err_cnt, exp_err_q.pop_front());
        check("locked_on_err", locked, 0);
      end
      if (frame_start) begin
        if (exp_fs_q.size() == 0) unexpected("frame_start");
        else check("frame_sum", frame_sum, exp_fs_q.pop_front());
        check("locked_on_frame_start", locked, 1);
      end
      if (locked !== prev_locked) begin
        if (exp_lock_q.size() == 0) unexpected("locked_change");
        else check("locked_change", locked, exp_lock_q.pop_front());
        prev_locked = locked;
      end
    end
  end

  initial begin
    #1_000_000;
    n_bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; pix_ce = 1'b0; hs = ~SP; vs = ~SP;
    vgar = '0; vgag = '0; vgab = '0;
    model_reset();
    repeat (2) @(negedge clk);
    pulse_reset();
    mon_on = 1'b1;

    // nominal stream: lock at 2nd vsync start, frame_start from the 3rd
    repeat (4) send_frame(-1, VS);
    check("locked_after_frames", locked, (st == 2) ? 1 : 0);

    // short line while locked, then relock
    send_frame(4, VS);
    repeat (3) send_frame(-1, VS);

    // vsync held one line too long
    send_frame(-1, VS + 1);
    repeat (3) send_frame(-1, VS);

    // reset in the middle of a locked frame
    send_part(0, 4, -1, VS);
    pulse_reset();
    send_part(5, VT - 1, -1, VS);
    repeat (3) send_frame(-1, VS);
    check("locked_after_reset_relock", locked, (st == 2) ? 1 : 0);

    // repeated VERIFY entry followed by error, saturating err_cnt
    repeat (260) begin
      send_line(10, 1'b1);
      send_line(10, 1'b0);
    end

    @(negedge clk);
    pix_ce = 1'b0;
    repeat (5) @(negedge clk);
    check("px_count", px_seen, px_pushed);
    check("err_cnt_final", err_cnt, err_cnt_m);
    check("err_cnt_saturated", err_cnt, 8'd255);
    check("px_q_left", exp_px_q.size(), 0);
    check("err_q_left", exp_err_q.size(), 0);
    check("fs_q_left", exp_fs_q.size(), 0);
    check("lock_q_left", exp_lock_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
